// File: rtl/lcd_status_writer.sv
// lcd_status_writer
//   Paints the 2x16 character LCD with the live board status. It shows the three ADC
//   delay settings and the DIP switch value. A frame is a snapshot of the inputs,
//   then 32 character writes, then one panel update request. A frame starts when the
//   inputs change, when force_refresh pulses, or when the periodic refresh counter
//   fires.
// Ports
//   CLK, RST            clock; asynchronous active-low reset
//   ad1_delay, ad2_delay, ad_valid_delay, DIP   live status inputs
//   force_refresh       one-cycle request for an immediate frame
//   lcd_row/col/char/we character write port, one character per lcd_we cycle
//   lcd_update          one-cycle request to push the frame buffer to the panel
//   lcd_busy            panel transfer in progress (stalls writes and updates)
//   frame_done          one-cycle pulse after a frame completes or times out
//   active              high whenever a frame is in progress
module lcd_status_writer #(
    parameter logic [23:0] REFRESH_CYCLES = 24'd6_000_000,
    parameter logic [7:0]  BUSY_TIMEOUT   = 8'd15
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] ad1_delay,
    input  logic [3:0] ad2_delay,
    input  logic [3:0] ad_valid_delay,
    input  logic [7:0] DIP,
    input  logic       force_refresh,
    output logic       lcd_row,
    output logic [3:0] lcd_col,
    output logic [7:0] lcd_char,
    output logic       lcd_we,
    output logic       lcd_update,
    input  logic       lcd_busy,
    output logic       frame_done,
    output logic       active
);

    localparam int unsigned SNAP_W = 20;
    localparam int unsigned IDX_W  = 5;
    localparam int unsigned CNT_W  = 24;
    localparam int unsigned TMO_W  = 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SNAP    = 3'd1,
        S_WRITE   = 3'd2,
        S_UPD     = 3'd3,
        S_WAIT_HI = 3'd4,
        S_WAIT_LO = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [SNAP_W-1:0]   snap_q, snap_d;
    logic                pending_q, pending_d;
    logic [CNT_W-1:0]    refresh_q, refresh_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                frame_done_q, frame_done_d;

    logic [SNAP_W-1:0]   live;
    logic                refresh_hit;
    logic                trigger;

    // Uppercase ASCII hex digit
    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + 8'(n);
        end
        return 8'h37 + 8'(n);
    endfunction

    // Character at frame position idx, taken from the snapshot only
    function automatic logic [7:0] char_at(input logic [IDX_W-1:0] idx,
                                           input logic [SNAP_W-1:0] s);
        logic [7:0] c;
        c = 8'h20;
        unique case (idx)
            5'd0:    c = 8'h41;                 // A
            5'd1:    c = 8'h31;                 // 1
            5'd2:    c = 8'h3A;                 // :
            5'd3:    c = hex_ascii(s[19:16]);
            5'd5:    c = 8'h41;                 // A
            5'd6:    c = 8'h32;                 // 2
            5'd7:    c = 8'h3A;                 // :
            5'd8:    c = hex_ascii(s[15:12]);
            5'd10:   c = 8'h41;                 // A
            5'd11:   c = 8'h56;                 // V
            5'd12:   c = 8'h3A;                 // :
            5'd13:   c = hex_ascii(s[11:8]);
            5'd16:   c = 8'h44;                 // D
            5'd17:   c = 8'h49;                 // I
            5'd18:   c = 8'h50;                 // P
            5'd19:   c = 8'h3A;                 // :
            5'd20:   c = hex_ascii(s[7:4]);
            5'd21:   c = hex_ascii(s[3:0]);
            default: c = 8'h20;
        endcase
        return c;
    endfunction

    assign live = {ad1_delay, ad2_delay, ad_valid_delay, DIP};

    // Free-running refresh counter; a zero period disables it entirely
    always_comb begin
        refresh_hit = 1'b0;
        refresh_d   = '0;
        if (REFRESH_CYCLES != 24'd0) begin
            refresh_hit = (refresh_q == REFRESH_CYCLES - 24'd1);
            refresh_d   = refresh_hit ? '0 : refresh_q + 24'd1;
        end
    end

    assign trigger = (live != snap_q) | force_refresh | refresh_hit;

    // State and datapath registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= S_IDLE;
            snap_q       <= '0;
            pending_q    <= 1'b0;
            refresh_q    <= '0;
            idx_q        <= '0;
            tmo_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            snap_q       <= snap_d;
            pending_q    <= pending_d;
            refresh_q    <= refresh_d;
            idx_q        <= idx_d;
            tmo_q        <= tmo_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next state; requests seen outside IDLE accumulate into one pending frame,
    // and the snapshot cycle itself absorbs them since it samples the live inputs
    always_comb begin
        state_d      = state_q;
        snap_d       = snap_q;
        pending_d    = pending_q | trigger;
        idx_d        = idx_q;
        tmo_d        = tmo_q;
        frame_done_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (pending_q | trigger) begin
                    state_d = S_SNAP;
                end
            end
            S_SNAP: begin
                snap_d    = live;
                pending_d = 1'b0;
                idx_d     = '0;
                state_d   = S_WRITE;
            end
            S_WRITE: begin
                if (!lcd_busy) begin
                    if (idx_q == 5'd31) begin
                        state_d = S_UPD;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            S_UPD: begin
                if (!lcd_busy) begin
                    tmo_d   = '0;
                    state_d = S_WAIT_HI;
                end
            end
            S_WAIT_HI: begin
                if (lcd_busy) begin
                    state_d = S_WAIT_LO;
                end else if (tmo_q == BUSY_TIMEOUT - 8'd1) begin
                    state_d      = S_IDLE;
                    frame_done_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_WAIT_LO: begin
                if (!lcd_busy) begin
                    state_d      = S_IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs; the write port reacts to lcd_busy in the same cycle so a stall
    // never lets a character through
    always_comb begin
        lcd_we     = 1'b0;
        lcd_row    = 1'b0;
        lcd_col    = '0;
        lcd_char   = '0;
        lcd_update = 1'b0;
        frame_done = frame_done_q;
        active     = (state_q != S_IDLE);
        if (state_q == S_WRITE && !lcd_busy) begin
            lcd_we   = 1'b1;
            lcd_row  = idx_q[4];
            lcd_col  = idx_q[3:0];
            lcd_char = char_at(idx_q, snap_q);
        end
        if (state_q == S_UPD && !lcd_busy) begin
            lcd_update = 1'b1;
        end
    end

endmodule

// File: tb/tb_lcd_status_writer.sv
module tb_lcd_status_writer;

    localparam int R = 100;
    localparam int T = 15;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] ad1_delay = '0;
    logic [3:0] ad2_delay = '0;
    logic [3:0] ad_valid_delay = '0;
    logic [7:0] DIP = '0;
    logic       force_refresh = 1'b0;
    logic       lcd_busy = 1'b0;
    logic       lcd_row, lcd_we, lcd_update, frame_done, active;
    logic [3:0] lcd_col;
    logic [7:0] lcd_char;

    always #5 CLK = ~CLK;

    lcd_status_writer #(
        .REFRESH_CYCLES(24'(R)),
        .BUSY_TIMEOUT  (8'(T))
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .ad1_delay     (ad1_delay),
        .ad2_delay     (ad2_delay),
        .ad_valid_delay(ad_valid_delay),
        .DIP           (DIP),
        .force_refresh (force_refresh),
        .lcd_row       (lcd_row),
        .lcd_col       (lcd_col),
        .lcd_char      (lcd_char),
        .lcd_we        (lcd_we),
        .lcd_update    (lcd_update),
        .lcd_busy      (lcd_busy),
        .frame_done    (frame_done),
        .active        (active)
    );

    typedef struct {
        logic       row;
        logic [3:0] col;
        logic [7:0] ch;
    } wr_t;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: frame phase, snapshot, pending request, counters
    int          m_ph = 0;      // 0 idle, 1 snap, 2 write, 3 update, 4 wait rise, 5 wait fall
    logic [19:0] m_snap = '0;
    bit          m_pend = 0;
    int          m_cnt = 0;
    int          m_k = 0;
    int          m_to = 0;
    bit          m_fd = 0;

    // Observation
    wr_t wq[$];
    int  cyc = 0, n_upd = 0, n_fd = 0, upd_cyc = 0, fd_cyc = 0;
    int  n_starts = 0, last_start = 0, start_delta = 0, first_wr_cyc = 0;
    logic act_prev = 1'b0;

    // Busy responder / stall control
    int  seen_upd = 0, busy_cnt = 0, resp_len = 3, stall_pct = 0;
    bit  resp_en = 1, hold_busy = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Expected 32-character frame text for a snapshot {ad1,ad2,adv,DIP}
    function automatic string frame_str(input logic [19:0] s);
        string f;
        f = $sformatf("A1:%h A2:%h AV:%h  DIP:%h          ",
                      s[19:16], s[15:12], s[11:8], s[7:0]);
        for (int i = 0; i < f.len(); i++) begin
            if (f.getc(i) >= 8'h61 && f.getc(i) <= 8'h66) begin
                f.putc(i, byte'(f.getc(i) - 8'd32));
            end
        end
        return f;
    endfunction

    task automatic model_step();
        logic [19:0] live;
        bit          hit, trig;
        logic        e_act, e_we, e_upd, e_fd, e_row;
        logic [3:0]  e_col;
        logic [7:0]  e_ch;
        string       fs;
        cyc++;
        if (!RST) begin
            chk($sformatf("in_reset@%0d", cyc),
                32'({active, lcd_we, lcd_update, frame_done, lcd_row, lcd_col, lcd_char}), 0);
            m_ph = 0; m_snap = '0; m_pend = 0; m_cnt = 0; m_k = 0; m_to = 0; m_fd = 0;
            act_prev = 1'b0;
            return;
        end
        live  = {ad1_delay, ad2_delay, ad_valid_delay, DIP};
        hit   = (m_cnt == R - 1);
        trig  = (live != m_snap) || force_refresh || hit;
        e_act = (m_ph != 0);
        e_we  = (m_ph == 2) && !lcd_busy;
        e_upd = (m_ph == 3) && !lcd_busy;
        e_fd  = m_fd;
        fs    = frame_str(m_snap);
        e_row = e_we ? 1'(m_k / 16) : 1'b0;
        e_col = e_we ? 4'(m_k % 16) : 4'd0;
        e_ch  = e_we ? fs.getc(m_k) : 8'd0;
        chk($sformatf("cycle@%0d {act,we,upd,done,row,col,char}", cyc),
            32'({active, lcd_we, lcd_update, frame_done, lcd_row, lcd_col, lcd_char}),
            32'({e_act, e_we, e_upd, e_fd, e_row, e_col, e_ch}));

        if (active && !act_prev) begin
            wq.delete();
            n_starts++;
            start_delta = cyc - last_start;
            last_start  = cyc;
        end
        act_prev = active;
        if (lcd_we) begin
            if (wq.size() == 0) first_wr_cyc = cyc;
            wq.push_back('{lcd_row, lcd_col, lcd_char});
        end
        if (lcd_update) begin n_upd++; upd_cyc = cyc; end
        if (frame_done) begin n_fd++; fd_cyc = cyc; end

        m_cnt = hit ? 0 : m_cnt + 1;
        m_fd  = 0;
        if (m_ph != 0) m_pend = m_pend || trig;
        case (m_ph)
            0: if (m_pend || trig) m_ph = 1;
            1: begin m_snap = live; m_pend = 0; m_k = 0; m_ph = 2; end
            2: if (e_we) begin
                   if (m_k == 31) m_ph = 3; else m_k++;
               end
            3: if (!lcd_busy) begin m_ph = 4; m_to = 0; end
            4: if (lcd_busy) m_ph = 5;
               else if (m_to == T - 1) begin m_ph = 0; m_fd = 1; end
               else m_to++;
            5: if (!lcd_busy) begin m_ph = 0; m_fd = 1; end
            default: m_ph = 0;
        endcase
    endtask

    task automatic tick();
        @(negedge CLK);
        model_step();
        @(posedge CLK);
        #1;
        if (n_upd != seen_upd) begin
            seen_upd = n_upd;
            if (resp_en && resp_len > 0) busy_cnt = resp_len;
        end
        if (busy_cnt > 0) begin
            lcd_busy = 1'b1;
            busy_cnt--;
        end else begin
            lcd_busy = hold_busy || (stall_pct > 0 && $urandom_range(0, 99) < stall_pct);
        end
    endtask

    task automatic run_until_fd(input string nm, input int budget);
        int n0, c;
        n0 = n_fd;
        c = 0;
        while (n_fd == n0 && c < budget) begin tick(); c++; end
        chk({nm, "_frame_done_seen"}, 32'(n_fd != n0), 1);
    endtask

    task automatic run_until_writes(input string nm, input int n, input int budget);
        int c;
        c = 0;
        while (wq.size() != n && c < budget) begin tick(); c++; end
        chk({nm, "_write_count_reached"}, 32'(wq.size()), 32'(n));
    endtask

    task automatic settle();
        int quiet, c;
        quiet = 0;
        c = 0;
        while (quiet < 3 && c < 400) begin
            tick();
            quiet = active ? 0 : quiet + 1;
            c++;
        end
        chk("settle_idle", 32'(quiet >= 3), 1);
    endtask

    task automatic pulse_force();
        force_refresh = 1'b1;
        tick();
        force_refresh = 1'b0;
    endtask

    task automatic check_frame(input string nm, input string tmpl);
        chk({nm, "_writes"}, 32'(wq.size()), 32);
        for (int i = 0; i < 32; i++) begin
            if (i < wq.size()) begin
                chk($sformatf("%s_pos%0d", nm, i),
                    32'({wq[i].row, wq[i].col, wq[i].ch}),
                    32'({1'(i / 16), 4'(i % 16), 8'(tmpl.getc(i))}));
            end
        end
    endtask

    initial begin
        int c0, nw, nu;
        #1 RST = 1'b0;
        #1;
        chk("reset_state",
            32'({active, lcd_we, lcd_update, frame_done, lcd_row, lcd_col, lcd_char}), 0);

        // Basic frame after reset release
        ad1_delay = 4'd5; ad2_delay = 4'd0; ad_valid_delay = 4'd8; DIP = 8'h81;
        repeat (3) tick();
        RST = 1'b1;
        c0 = cyc;
        nu = n_upd;
        run_until_fd("frame1", 200);
        chk("first_we_latency", 32'(first_wr_cyc - c0), 3);
        chk("frame1_r0c3", 32'(wq[3].ch), 32'h35);
        chk("frame1_r0c8", 32'(wq[8].ch), 32'h30);
        chk("frame1_r0c13", 32'(wq[13].ch), 32'h38);
        chk("frame1_r1c4", 32'(wq[20].ch), 32'h38);
        chk("frame1_r1c5", 32'(wq[21].ch), 32'h31);
        chk("frame1_updates", 32'(n_upd - nu), 1);
        check_frame("frame1", "A1:5 A2:0 AV:8  DIP:81          ");

        // DIP change plus force_refresh
        settle();
        DIP = 8'hAF;
        pulse_force();
        run_until_fd("frame2", 200);
        chk("frame2_r1c4", 32'(wq[20].ch), 32'h41);
        chk("frame2_r1c5", 32'(wq[21].ch), 32'h46);
        check_frame("frame2", "A1:5 A2:0 AV:8  DIP:AF          ");

        // Ten-cycle busy stall at idx 7
        settle();
        pulse_force();
        run_until_writes("stall", 7, 60);
        hold_busy = 1'b1;
        lcd_busy  = 1'b1;
        repeat (10) tick();
        chk("stall_no_writes", 32'(wq.size()), 7);
        hold_busy = 1'b0;
        run_until_fd("stall", 200);
        chk("stall_r0c7_colon", 32'(wq[7].ch), 32'h3A);
        check_frame("stall", "A1:5 A2:0 AV:8  DIP:AF          ");

        // Input change mid-frame: current frame unchanged, one more follows
        settle();
        pulse_force();
        run_until_writes("midchg", 10, 60);
        ad2_delay = 4'd3;
        run_until_fd("midchg_a", 200);
        chk("midchg_old_r0c8", 32'(wq[8].ch), 32'h30);
        run_until_fd("midchg_b", 200);
        chk("midchg_new_r0c8", 32'(wq[8].ch), 32'h33);
        check_frame("midchg_b", "A1:5 A2:3 AV:8  DIP:AF          ");

        // Busy never rises after update
        settle();
        resp_en = 0;
        pulse_force();
        run_until_fd("timeout", 200);
        chk("timeout_delay", 32'(fd_cyc - upd_cyc), 16);
        resp_en = 1;

        // Periodic refresh with static inputs
        settle();
        nw = n_starts;
        c0 = 0;
        while (n_starts < nw + 2 && c0 < 400) begin tick(); c0++; end
        chk("refresh_starts", 32'(n_starts - nw), 2);
        chk("refresh_period", 32'(start_delta), 100);

        // Reset in the middle of a frame
        settle();
        pulse_force();
        run_until_writes("rst", 20, 60);
        RST = 1'b0;
        #1;
        chk("rst_async_outs",
            32'({active, lcd_we, lcd_update, frame_done, lcd_row, lcd_col, lcd_char}), 0);
        nu = n_upd;
        repeat (5) tick();
        chk("rst_no_update", 32'(n_upd - nu), 0);
        RST = 1'b1;
        run_until_fd("after_rst", 200);
        check_frame("after_rst", "A1:5 A2:3 AV:8  DIP:AF          ");

        // Randomized traffic against the model
        stall_pct = 20;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                resp_en  = ($urandom_range(0, 3) != 0);
                resp_len = $urandom_range(0, 5);
            end
            if ($urandom_range(0, 49) == 0) begin
                case ($urandom_range(0, 3))
                    0: ad1_delay = 4'($urandom);
                    1: ad2_delay = 4'($urandom);
                    2: ad_valid_delay = 4'($urandom);
                    default: DIP = 8'($urandom);
                endcase
            end
            force_refresh = ($urandom_range(0, 99) == 0);
            tick();
        end
        force_refresh = 1'b0;
        stall_pct = 0;
        resp_en = 1;
        resp_len = 3;
        settle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
